// File: rtl/program_loader_if.sv
// Byte-stream input and cache write-port bundle for the program loader.
// slave = the loader, master = the byte source / cache side.
interface program_loader_if;
  logic [7:0]  ip_byte_data;
  logic        ip_byte_valid;
  logic        op_byte_ready;
  logic [31:0] op_wr_addr;
  logic [31:0] op_wr_data;
  logic        op_wr_en;
  logic        op_wr_done_ctrl;

  modport slave (
    input  ip_byte_data, ip_byte_valid,
    output op_byte_ready, op_wr_addr, op_wr_data, op_wr_en, op_wr_done_ctrl
  );

  modport master (
    output ip_byte_data, ip_byte_valid,
    input  op_byte_ready, op_wr_addr, op_wr_data, op_wr_en, op_wr_done_ctrl
  );
endinterface

// File: rtl/program_loader.sv
// Loads a program from a byte stream: 4-byte little-endian word-count header,
// then little-endian words written to sequential cache addresses.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic             ip_clk,
  input  logic             ip_rst,
  input  logic             ip_load_start,
  input  logic             ip_abort,
  program_loader_if.slave  bus,
  output logic             op_busy,
  output logic             op_err
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

  state_t            r_state, w_state_nxt;
  logic [23:0]       r_shift, w_shift_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [IDX_W-1:0]  r_index, w_index_nxt;
  logic [IDX_W-1:0]  r_count, w_count_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_fire;
  logic [31:0]       w_word;

  // Incoming byte lands in the top lane, so the first byte ends up in bits 7:0.
  assign w_fire = bus.ip_byte_valid & r_ready;
  assign w_word = {bus.ip_byte_data, r_shift};

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_index_nxt    = r_index;
    w_count_nxt    = r_count;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_wr_en_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;

    if (ip_abort) begin
      // Abort wins: any partial word is dropped; a write already on the port still completes.
      w_state_nxt    = S_IDLE;
      w_err_nxt      = 1'b0;
      w_byte_cnt_nxt = 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (ip_load_start) begin
            w_state_nxt    = S_HDR;
            w_err_nxt      = 1'b0;
            w_index_nxt    = '0;
            w_byte_cnt_nxt = 2'd0;
          end
        end
        S_HDR: begin
          if (w_fire) begin
            w_shift_nxt    = w_word[31:8];
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if ((w_word == 32'd0) || (w_word > 32'(MAX_WORDS))) begin
                w_state_nxt = S_ERR;
                w_err_nxt   = 1'b1;
              end else begin
                w_count_nxt = IDX_W'(w_word);
                w_state_nxt = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
            w_shift_nxt    = w_word[31:8];
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              w_wr_en_nxt = 1'b1;
              w_data_nxt  = w_word;
              w_addr_nxt  = BASE_ADDR + (32'(r_index) << 2);
              w_index_nxt = r_index + IDX_W'(1);
              if (r_index == (r_count - IDX_W'(1))) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_ready_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA);
    w_busy_nxt  = w_ready_nxt;
  end

  always_ff @(posedge ip_clk or negedge ip_rst) begin
    if (!ip_rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_byte_cnt <= 2'd0;
      r_index    <= '0;
      r_count    <= '0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_index    <= w_index_nxt;
      r_count    <= w_count_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.op_byte_ready   = r_ready;
  assign bus.op_wr_addr      = r_addr;
  assign bus.op_wr_data      = r_data;
  assign bus.op_wr_en        = r_wr_en;
  assign bus.op_wr_done_ctrl = r_done;
  assign op_busy             = r_busy;
  assign op_err              = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one instance at BASE_ADDR 0, one at 0x4000,
// both fed the same stream; writes are captured per instance and checked.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_start, abort, byte_valid;
  logic [7:0] byte_data;
  logic       busy0, err0, busy1, err1;

  program_loader_if u_if0 ();
  program_loader_if u_if1 ();

  assign u_if0.ip_byte_data  = byte_data;
  assign u_if0.ip_byte_valid = byte_valid;
  assign u_if1.ip_byte_data  = byte_data;
  assign u_if1.ip_byte_valid = byte_valid;

  program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) u_dut0 (
    .ip_clk(clk), .ip_rst(rst_n), .ip_load_start(load_start), .ip_abort(abort),
    .bus(u_if0), .op_busy(busy0), .op_err(err0)
  );

  program_loader #(.BASE_ADDR(32'h0000_4000), .MAX_WORDS(1024)) u_dut1 (
    .ip_clk(clk), .ip_rst(rst_n), .ip_load_start(load_start), .ip_abort(abort),
    .bus(u_if1), .op_busy(busy1), .op_err(err1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_done;
  } vec_t;

  wr_t  q0[$];
  wr_t  q1[$];
  vec_t tbl[4];
  int   cyc = 0;
  int   last_acc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture writes mid-cycle, tagged with the cycle they were visible in.
  always @(negedge clk) begin
    if (u_if0.op_wr_en === 1'b1)
      q0.push_back('{u_if0.op_wr_addr, u_if0.op_wr_data, u_if0.op_wr_done_ctrl, cyc});
    if (u_if1.op_wr_en === 1'b1)
      q1.push_back('{u_if1.op_wr_addr, u_if1.op_wr_data, u_if1.op_wr_done_ctrl, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 200;
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (u_if0.op_byte_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    last_acc   = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic send_u32(input logic [31:0] w, input int gap);
    send_byte(w[7:0]);   idle(gap);
    send_byte(w[15:8]);  idle(gap);
    send_byte(w[23:16]); idle(gap);
    send_byte(w[31:24]); idle(gap);
  endtask

  task automatic run_table(input string tag, input int gap);
    int acc4[4];
    q0.delete();
    q1.delete();
    pulse_start();
    send_u32(32'd4, gap);
    chk({tag, "_busy_data"}, 32'(busy0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(tbl[i].b0); idle(gap);
      send_byte(tbl[i].b1); idle(gap);
      send_byte(tbl[i].b2); idle(gap);
      send_byte(tbl[i].b3);
      acc4[i] = last_acc;
      idle(gap);
    end
    idle(3);
    chk({tag, "_wr_count"}, 32'(q0.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q0.size()) begin
        chk($sformatf("%s_addr[%0d]", tag, i), q0[i].addr, tbl[i].exp_addr);
        chk($sformatf("%s_data[%0d]", tag, i), q0[i].data, tbl[i].exp_data);
        chk($sformatf("%s_done[%0d]", tag, i), 32'(q0[i].done), 32'(tbl[i].exp_done));
        chk($sformatf("%s_latency[%0d]", tag, i), 32'(q0[i].cyc), 32'(acc4[i] + 1 - 1));
      end
    end
    chk({tag, "_busy_after"}, 32'(busy0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h03, 8'hA3, 8'h02, 8'h00, 32'h0000_0000, 32'h0002_A303, 1'b0};
    tbl[1] = '{8'hB7, 8'h02, 8'h00, 8'h02, 32'h0000_0004, 32'h0200_02B7, 1'b0};
    tbl[2] = '{8'h03, 8'hA3, 8'h02, 8'h00, 32'h0000_0008, 32'h0002_A303, 1'b0};
    tbl[3] = '{8'h83, 8'hA3, 8'h42, 8'h00, 32'h0000_000C, 32'h0042_A383, 1'b1};

    rst_n = 1'b0; load_start = 1'b0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    idle(3);
    chk("rst_ready", 32'(u_if0.op_byte_ready), 32'd0);
    chk("rst_wr_en", 32'(u_if0.op_wr_en), 32'd0);
    chk("rst_addr",  u_if0.op_wr_addr, 32'd0);
    chk("rst_data",  u_if0.op_wr_data, 32'd0);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_err",   32'(err0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_table("normal", 0);
    run_table("throttle1", 1);
    run_table("throttle3", 3);

    // Header error: zero count, then one above MAX_WORDS, then a clean session.
    q0.delete();
    pulse_start();
    send_u32(32'd0, 0);
    idle(2);
    chk("hdr0_err",    32'(err0), 32'd1);
    chk("hdr0_ready",  32'(u_if0.op_byte_ready), 32'd0);
    chk("hdr0_busy",   32'(busy0), 32'd0);
    chk("hdr0_writes", 32'(q0.size()), 32'd0);
    pulse_start();
    chk("err_clear_on_start", 32'(err0), 32'd0);
    send_u32(32'h0000_0401, 0);
    idle(2);
    chk("hdrbig_err",    32'(err0), 32'd1);
    chk("hdrbig_ready",  32'(u_if0.op_byte_ready), 32'd0);
    chk("hdrbig_writes", 32'(q0.size()), 32'd0);
    pulse_start();
    send_u32(32'd1, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(3);
    chk("recover_err",    32'(err0), 32'd0);
    chk("recover_writes", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) begin
      chk("recover_data", q0[0].data, 32'h4433_2211);
      chk("recover_addr", q0[0].addr, 32'h0000_0000);
      chk("recover_done", 32'(q0[0].done), 32'd1);
    end

    // Abort mid-word: one full word written, partial word dropped.
    q0.delete();
    pulse_start();
    send_u32(32'd2, 0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01); send_byte(8'h02);
    pulse_abort();
    idle(3);
    chk("abort_writes", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) begin
      chk("abort_addr", q0[0].addr, 32'h0000_0000);
      chk("abort_data", q0[0].data, 32'hDDCC_BBAA);
      chk("abort_done", 32'(q0[0].done), 32'd0);
    end
    chk("abort_busy",  32'(busy0), 32'd0);
    chk("abort_ready", 32'(u_if0.op_byte_ready), 32'd0);
    q0.delete();
    pulse_start();
    send_u32(32'd1, 0);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    idle(3);
    chk("restart_writes", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) begin
      chk("restart_addr", q0[0].addr, 32'h0000_0000);
      chk("restart_data", q0[0].data, 32'hDEAD_BEEF);
      chk("restart_done", 32'(q0[0].done), 32'd1);
    end

    // Abort in the cycle the final write is on the port: write and done still issue.
    q0.delete();
    pulse_start();
    send_u32(32'd1, 0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
    pulse_abort();
    idle(2);
    chk("abortfin_writes", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) begin
      chk("abortfin_data", q0[0].data, 32'h8000_0001);
      chk("abortfin_done", 32'(q0[0].done), 32'd1);
    end
    chk("abortfin_busy", 32'(busy0), 32'd0);

    // Asynchronous reset mid-DATA, asserted between clock edges.
    pulse_start();
    send_u32(32'd2, 0);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    send_byte(8'h50); send_byte(8'h60);
    idle(1);
    chk("prerst_data", u_if0.op_wr_data, 32'h4030_2010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(u_if0.op_byte_ready), 32'd0);
    chk("arst_busy",  32'(busy0), 32'd0);
    chk("arst_data",  u_if0.op_wr_data, 32'd0);
    chk("arst_addr",  u_if1.op_wr_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    q0.delete();
    q1.delete();
    byte_data  = 8'h99;
    byte_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (i == 4) chk("postrst_ready", 32'(u_if0.op_byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    idle(2);
    chk("postrst_writes", 32'(q0.size()), 32'd0);

    // Fresh session after reset; the second instance shows the base offset.
    q0.delete();
    q1.delete();
    pulse_start();
    send_u32(32'd1, 0);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    idle(3);
    chk("base0_writes", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) chk("base0_addr", q0[0].addr, 32'h0000_0000);
    chk("base_writes", 32'(q1.size()), 32'd1);
    if (q1.size() > 0) begin
      chk("base_addr", q1[0].addr, 32'h0000_4000);
      chk("base_data", q1[0].data, 32'h1234_5678);
      chk("base_done", 32'(q1[0].done), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader upstream of the cache unit.
- Receives a serial byte stream (from the UART/host I/O bridge) made of a 4-byte word-count header followed by little-endian 32-bit words.
- Assembles each group of four bytes into a word and issues single-cycle writes on the cache's I/O write port at sequential word addresses.
- Flags completion with a write-done strobe on the final write.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first program word; must be word aligned.
- MAX_WORDS, 1024, largest accepted word count; counts above this are rejected.

Ports:
- ip_clk  input  1  system clock, rising edge
- ip_rst  input  1  asynchronous, active-low reset
- ip_load_start  input  1  single-cycle pulse that starts a load session
- ip_abort  input  1  cancels any session and returns to IDLE
- ip_byte_data  input  8  incoming stream byte
- ip_byte_valid  input  1  ip_byte_data is valid this cycle
- op_byte_ready  output  1  loader accepts a byte this cycle; a byte transfers when valid&ready
- op_wr_addr  output  32  cache write address
- op_wr_data  output  32  cache write data
- op_wr_en  output  1  cache write strobe, one cycle per word
- op_wr_done_ctrl  output  1  high together with the final op_wr_en of a session
- op_busy  output  1  high in HDR and DATA
- op_err  output  1  header error flag, sticky until the next start or abort

Behaviour:
- Reset (ip_rst=0, asynchronous) forces state IDLE and clears every output, byte counter, word index, count and shift register to 0.
- States:
  - IDLE: op_byte_ready=0. ip_load_start=1 -> HDR; clears op_err, word index and byte counter.
  - HDR: op_byte_ready=1. Accepted bytes shift in little-endian (first byte = bits 7:0). On the 4th byte, count is latched. If count==0 or count>MAX_WORDS -> ERR. Otherwise -> DATA.
  - DATA: op_byte_ready=1. Bytes are assembled little-endian. On the 4th byte of a word, the next cycle drives:
    - op_wr_en=1
    - op_wr_data = assembled word
    - op_wr_addr = BASE_ADDR + 4*index (32-bit, wraps modulo 2^32)
    - Then index increments. If the word was index count-1, op_wr_done_ctrl=1 in the same cycle and state -> DONE.
  - DONE: op_byte_ready=0, lasts one cycle -> IDLE.
  - ERR: op_err=1, op_byte_ready=0. Stays until ip_load_start (-> HDR, op_err cleared) or ip_abort (-> IDLE, op_err cleared).
- Write latency: op_wr_en is registered and asserts exactly one cycle after the 4th byte of a word is accepted.
- op_wr_en, op_wr_done_ctrl are one-cycle pulses. op_wr_addr and op_wr_data hold their last value between pulses.
- A byte is consumed only when ip_byte_valid&op_byte_ready. Bytes with valid=0 are ignored; gaps of any length are legal.
- Bytes presented while ready=0 are neither consumed nor stored.
- ip_abort has priority over every other input in every state:
  - Next state IDLE.
  - Partial word discarded; no write and no done pulse issued.
- ip_load_start while in HDR or DATA is ignored; only ip_abort restarts a session.
- If ip_abort coincides with the cycle a final write is due, the pending op_wr_en and op_wr_done_ctrl are still issued; the state goes to IDLE.
- Reset mid-session: the session is abandoned and no further writes are issued.

Test Plan:
- Normal load:
  - Stimulus: start; bytes 04 00 00 00, 03 A3 02 00, B7 02 00 02, 03 A3 02 00, 83 A3 42 00.
  - Required: writes 0x0002A303@0x0, 0x020002B7@0x4, 0x0002A303@0x8, 0x0042A383@0xC.
  - Required: op_wr_done_ctrl high only with the 0xC write; op_busy low afterwards.
- Throttled stream:
  - Stimulus: same data with ip_byte_valid toggling 1-0-1 and 3-cycle gaps.
  - Required: identical write sequence; each op_wr_en exactly one cycle after its 4th byte.
- Header errors:
  - Stimulus: count 00 00 00 00 -> required: op_err=1, no writes, op_byte_ready=0.
  - Stimulus: count 0x00000401 with MAX_WORDS=1024 -> required: same error response.
  - Stimulus: new start -> required: op_err clears and a valid session succeeds.
- Abort mid-word:
  - Stimulus: count=2, one full word, then 2 bytes, then ip_abort.
  - Required: exactly one write (addr 0x0); no done pulse; state IDLE.
  - Required: a following session restarts at BASE_ADDR.
- Asynchronous reset:
  - Stimulus: drive ip_rst low between clock edges during DATA.
  - Required: outputs go to 0 immediately; no writes after reset is released until a new start.
- Base offset:
  - Stimulus: BASE_ADDR=32'h00004000, count=1, word 0x12345678.
  - Required: single write 0x12345678@0x4000 with op_wr_done_ctrl=1.
